// File: rtl/spike_isi_logger.sv
// spike_isi_logger
//
// Measures the inter-spike interval (ISI) of a neuron's spike train, in clock
// cycles, and queues the measurements in a small show-ahead FIFO. A consumer
// drains the FIFO over a valid/ready handshake.
//
// Optional feature macro: SPIKE_ISI_DROP_CNT_EN
//   When defined, the drop_cnt port is added. It is a saturating 8-bit count
//   of ISI words lost because the FIFO was full.
//
// Parameters:
//   ISI_W  width of the interval counter and of each FIFO word
//   DEPTH  FIFO entries, a power of two and at least 2
//
// Ports:
//   clk         clock
//   rst         asynchronous active-high reset
//   en          logging enable; low forces IDLE and clears the interval counter
//   spike_in    raw spike train from the neuron
//   isi_data    FIFO head word (don't-care while isi_valid is low)
//   isi_valid   FIFO non-empty
//   isi_ready   consumer accepts the head word
//   fifo_count  number of stored words
//   armed       high while an interval is being timed (state COUNTING)
//   drop_cnt    dropped-word count (only with SPIKE_ISI_DROP_CNT_EN)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | logging disabled, interval counter held at 0
// S_WAIT_1ST | enabled, waiting for the spike that starts the first interval
// S_COUNTING | timing an interval; each spike pushes it and restarts timing

module spike_isi_logger #(
    parameter int ISI_W = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       spike_in,
    output logic [ISI_W-1:0]           isi_data,
    output logic                       isi_valid,
    input  logic                       isi_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       armed
`ifdef SPIKE_ISI_DROP_CNT_EN
    ,
    output logic [7:0]                 drop_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_1ST = 2'd1,
        S_COUNTING = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_spike_q;
    logic [ISI_W-1:0]   r_cnt;
    logic [ISI_W-1:0]   w_cnt_nxt;
    logic               w_event;
    logic               w_push;
    logic               w_pop;
    logic               w_push_ok;
    logic               w_has_room;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [ISI_W-1:0]   r_mem [DEPTH];

    // Rising edge only, so a spike held high for several cycles is one event.
    assign w_event = spike_in & ~r_spike_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_spike_q <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_spike_q <= spike_in;
            r_cnt     <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        if (!en) begin
            // Disable wins over a coincident spike.
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_WAIT_1ST;
                    w_cnt_nxt   = '0;
                end
                S_WAIT_1ST: begin
                    if (w_event) begin
                        w_state_nxt = S_COUNTING;
                        w_cnt_nxt   = ISI_W'(1);
                    end
                end
                S_COUNTING: begin
                    if (w_event) begin
                        w_push    = 1'b1;
                        w_cnt_nxt = ISI_W'(1);
                    end else if (r_cnt != '1) begin
                        // An all-ones word reads as "at least this long".
                        w_cnt_nxt = r_cnt + ISI_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign armed = (r_state == S_COUNTING);

    // A pop in the same cycle frees the slot, so a full FIFO can still
    // accept a push when the consumer is reading.
    assign isi_valid  = (r_count != '0);
    assign w_pop      = isi_valid & isi_ready;
    assign w_has_room = (r_count < CNT_W'(DEPTH));
    assign w_push_ok  = w_push & (w_has_room | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: it is only ever read when isi_valid is high.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= r_cnt;
        end
    end

    assign isi_data   = r_mem[r_rd_ptr];
    assign fifo_count = r_count;

`ifdef SPIKE_ISI_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_push & ~w_push_ok & (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_spike_isi_logger.sv
module tb_spike_isi_logger;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        spike_in;
    logic        isi_ready;
    logic [15:0] isi_data;
    logic        isi_valid;
    logic [3:0]  fifo_count;
    logic        armed;

    logic        en2;
    logic        spike2;
    logic        ready2;
    logic [3:0]  isi_data2;
    logic        isi_valid2;
    logic [1:0]  fifo_count2;
    logic        armed2;

`ifdef SPIKE_ISI_DROP_CNT_EN
    logic [7:0]  drop_cnt;
    logic [7:0]  drop_cnt2;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spike_isi_logger #(.ISI_W(16), .DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .spike_in   (spike_in),
        .isi_data   (isi_data),
        .isi_valid  (isi_valid),
        .isi_ready  (isi_ready),
        .fifo_count (fifo_count),
        .armed      (armed)
`ifdef SPIKE_ISI_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    spike_isi_logger #(.ISI_W(4), .DEPTH(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .en         (en2),
        .spike_in   (spike2),
        .isi_data   (isi_data2),
        .isi_valid  (isi_valid2),
        .isi_ready  (ready2),
        .fifo_count (fifo_count2),
        .armed      (armed2)
`ifdef SPIKE_ISI_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Next rising edge of spike_in lands exactly n edges after the previous one.
    task automatic do_isi(input int n);
        repeat (n - 1) tick();
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
    endtask

    initial begin
        int exp_drain [8];
        exp_drain = '{3, 4, 5, 6, 7, 8, 9, 13};

        rst = 1'b1; en = 1'b0; spike_in = 1'b0; isi_ready = 1'b0;
        en2 = 1'b0; spike2 = 1'b0; ready2 = 1'b0;
        tick();
        tick();
        check("rst_count", 32'(fifo_count), 0);
        check("rst_valid", 32'(isi_valid), 0);
        check("rst_armed", 32'(armed), 0);
`ifdef SPIKE_ISI_DROP_CNT_EN
        check("rst_drop", 32'(drop_cnt), 0);
`endif
        rst = 1'b0;
        tick();

        // Regular spiking every 10 cycles, consumer always ready.
        isi_ready = 1'b1;
        en = 1'b1;
        tick();
        check("reg_wait_armed", 32'(armed), 0);
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        check("reg_first_armed", 32'(armed), 1);
        check("reg_first_nopush", 32'(isi_valid), 0);
        for (int k = 0; k < 3; k++) begin
            do_isi(10);
            check("reg_valid", 32'(isi_valid), 1);
            check("reg_data", 32'(isi_data), 10);
            check("reg_count", 32'(fifo_count), 1);
        end

        // Wide pulse: high 3 cycles, next rising edge 7 cycles after the first.
        en = 1'b0;
        tick();
        check("wide_idle_armed", 32'(armed), 0);
        check("wide_drained", 32'(fifo_count), 0);
        isi_ready = 1'b0;
        en = 1'b1;
        tick();
        spike_in = 1'b1;
        tick();
        tick();
        tick();
        spike_in = 1'b0;
        repeat (4) tick();
        check("wide_no_extra", 32'(fifo_count), 0);
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        check("wide_count", 32'(fifo_count), 1);
        check("wide_data", 32'(isi_data), 7);
        isi_ready = 1'b1;
        tick();
        isi_ready = 1'b0;
        check("wide_pop", 32'(fifo_count), 0);

        // Fill: ISIs 2..11 with no reader; the last two are dropped.
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        for (int i = 2; i <= 11; i++) do_isi(i);
        check("full_count", 32'(fifo_count), 8);
        check("full_head", 32'(isi_data), 2);
`ifdef SPIKE_ISI_DROP_CNT_EN
        check("full_drop", 32'(drop_cnt), 2);
`endif
        // Push and pop on the same edge while full.
        repeat (12) tick();
        spike_in = 1'b1;
        isi_ready = 1'b1;
        tick();
        spike_in = 1'b0;
        isi_ready = 1'b0;
        check("fullpp_count", 32'(fifo_count), 8);
        check("fullpp_head", 32'(isi_data), 3);
`ifdef SPIKE_ISI_DROP_CNT_EN
        check("fullpp_drop", 32'(drop_cnt), 2);
`endif
        isi_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check("drain_data", 32'(isi_data), 32'(exp_drain[j]));
            tick();
        end
        check("drain_count", 32'(fifo_count), 0);
        check("drain_valid", 32'(isi_valid), 0);
        tick();
        check("empty_ready_noop", 32'(fifo_count), 0);
        isi_ready = 1'b0;

        // Enable drop with 3 entries stored, then re-enable.
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        do_isi(4);
        do_isi(5);
        do_isi(6);
        repeat (3) tick();
        en = 1'b0;
        tick();
        check("dis_armed", 32'(armed), 0);
        check("dis_count", 32'(fifo_count), 3);
        check("dis_head", 32'(isi_data), 4);
        en = 1'b1;
        tick();
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        check("reen_first_nopush", 32'(fifo_count), 3);
        check("reen_armed", 32'(armed), 1);
        isi_ready = 1'b1;
        tick();
        isi_ready = 1'b0;
        check("reen_pop_head", 32'(isi_data), 5);
        check("reen_pop_count", 32'(fifo_count), 2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_count", 32'(fifo_count), 0);
        check("async_rst_valid", 32'(isi_valid), 0);
        check("async_rst_armed", 32'(armed), 0);
        tick();
        rst = 1'b0;
        en = 1'b0;
        tick();

        // Saturation with a 4-bit counter: events 40 cycles apart.
        en2 = 1'b1;
        tick();
        spike2 = 1'b1;
        tick();
        spike2 = 1'b0;
        repeat (39) tick();
        check("sat_nopush_yet", 32'(fifo_count2), 0);
        spike2 = 1'b1;
        tick();
        spike2 = 1'b0;
        check("sat_valid", 32'(isi_valid2), 1);
        check("sat_data", 32'(isi_data2), 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
